cpx_ld_rtn_gen: RTL and testbench

Verification-environment transmitter that produces CPX load-return packets (rtntype 4'b0000) toward a core's I$/load path. It buffers load requests, ages each for a minimum latency, and emits one return packet per cycle under sink backpressure. It guarantees that non-cacheable (nc) returns never carry the I$ way-valid/invalidate bit (wv), which keeps downstream nc-invalidate monitors quiet. An optional compile-time error-injection path deliberately violates that rule so the monitors can be exercised.

---
 rtl/cpx_ld_rtn_gen.sv | 89 ++++++++
 tb/tb_cpx_ld_rtn_gen.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/cpx_ld_rtn_gen.sv
// cpx_ld_rtn_gen: buffered CPX load-return generator with minimum latency and sink backpressure.
// Optional NC_INV_ERR_INJ_EN forces wv on the next nc return after an err_inj pulse.
module cpx_ld_rtn_gen #(
    parameter int DEPTH    = 4,
    parameter int MIN_LAT  = 2,
    parameter int COREID_W = 10
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_vld,
    output logic                req_rdy,
    input  logic                req_nc,
    input  logic                req_inv,
    input  logic [COREID_W-1:0] req_coreid,
    input  logic                cpx_stall,
    input  logic                err_inj,
    output logic                cpxpkt_vld,
    output logic [3:0]          cpxpkt_rtntype,
    output logic                nc,
    output logic                wv,
    output logic [COREID_W-1:0] coreid,
    output logic [7:0]          inv_supp_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int GW = $clog2(MIN_LAT + 1);

    logic [DEPTH-1:0]    f_nc, f_inv;
    logic [COREID_W-1:0] f_core [DEPTH];
    logic [GW-1:0]       f_age  [DEPTH];
    logic [AW-1:0]       rptr, wptr;
    logic [AW:0]         count;
    logic                push, pop, head_wv;

    assign cpxpkt_rtntype = 4'b0000;
    assign req_rdy = ~rst && (count < (AW+1)'(DEPTH));
    assign push    = req_vld & req_rdy;
    assign pop     = (count != '0) && (f_age[rptr] == GW'(MIN_LAT)) && ~cpx_stall;

`ifdef NC_INV_ERR_INJ_EN
    logic inj_flag;
    assign head_wv = f_inv[rptr] | (inj_flag & f_nc[rptr]);
    always_ff @(posedge clk) begin
        if (rst)
            inj_flag <= 1'b0;
        else
            inj_flag <= (inj_flag & ~(pop & f_nc[rptr])) | err_inj;
    end
`else
    logic unused_err_inj;
    assign unused_err_inj = err_inj;
    assign head_wv = f_inv[rptr];
`endif

    // Age counts the acceptance edge itself, so an entry accepted at edge N is poppable at N+MIN_LAT.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++)
            f_age[i] <= (push && wptr == AW'(i)) ? GW'(1) :
                        (f_age[i] == GW'(MIN_LAT)) ? f_age[i] : f_age[i] + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rptr         <= '0;
            wptr         <= '0;
            count        <= '0;
            cpxpkt_vld   <= 1'b0;
            nc           <= 1'b0;
            wv           <= 1'b0;
            coreid       <= '0;
            inv_supp_cnt <= '0;
        end else begin
            if (push) begin
                f_nc[wptr]   <= req_nc;
                f_inv[wptr]  <= req_inv & ~req_nc;
                f_core[wptr] <= req_coreid;
                wptr         <= wptr + 1'b1;
            end
            if (pop)
                rptr <= rptr + 1'b1;
            count      <= count + (AW+1)'(push) - (AW+1)'(pop);
            cpxpkt_vld <= pop;
            nc         <= pop & f_nc[rptr];
            wv         <= pop & head_wv;
            coreid     <= pop ? f_core[rptr] : '0;
            if (push && req_nc && req_inv && inv_supp_cnt != 8'hff)
                inv_supp_cnt <= inv_supp_cnt + 8'd1;
        end
    end
endmodule

// File: tb/tb_cpx_ld_rtn_gen.sv
// tb_cpx_ld_rtn_gen: directed vector table plus randomized run against a queue-based reference model.
module tb_cpx_ld_rtn_gen;
    localparam int DEPTH = 4, MIN_LAT = 2, CW = 10;

    logic          clk = 0, rst = 1, req_vld = 0, req_nc = 0, req_inv = 0, cpx_stall = 0, err_inj = 0;
    logic [CW-1:0] req_coreid = '0;
    logic          req_rdy, cpxpkt_vld, nc, wv;
    logic [3:0]    cpxpkt_rtntype;
    logic [CW-1:0] coreid;
    logic [7:0]    inv_supp_cnt;

    cpx_ld_rtn_gen #(.DEPTH(DEPTH), .MIN_LAT(MIN_LAT), .COREID_W(CW)) dut (
        .clk(clk), .rst(rst), .req_vld(req_vld), .req_rdy(req_rdy), .req_nc(req_nc),
        .req_inv(req_inv), .req_coreid(req_coreid), .cpx_stall(cpx_stall), .err_inj(err_inj),
        .cpxpkt_vld(cpxpkt_vld), .cpxpkt_rtntype(cpxpkt_rtntype), .nc(nc), .wv(wv),
        .coreid(coreid), .inv_supp_cnt(inv_supp_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    typedef struct {
        bit rst, vld, nc, inv; int core; bit stall;
        bit e_vld, e_nc, e_wv; int e_core; bit e_rdy; int e_cnt;
    } vec_t;
    vec_t tbl[36];

    function automatic vec_t mk(bit r, bit v, bit n, bit i, int c, bit s,
                                bit ev, bit en, bit ew, int ec, bit er, int cnt);
        vec_t t;
        t.rst = r; t.vld = v; t.nc = n; t.inv = i; t.core = c; t.stall = s;
        t.e_vld = ev; t.e_nc = en; t.e_wv = ew; t.e_core = ec; t.e_rdy = er; t.e_cnt = cnt;
        return t;
    endfunction

    typedef struct { bit nc; bit inv; logic [CW-1:0] core; int t; } ent_t;
    ent_t q[$];
    int   cyc = 0, m_cnt = 0, nc_wv_seen = 0;
    bit   m_flag = 0;

    // Reference: entries are timestamped at acceptance and leave in order once MIN_LAT edges have passed.
    task automatic cycle(input bit r, input bit v, input bit n, input bit i,
                         input logic [CW-1:0] c, input bit s, input bit e);
        bit ev = 0, en = 0, ew = 0, can_push, do_pop;
        logic [CW-1:0] ec = '0;
        ent_t h, nw;
        rst = r; req_vld = v; req_nc = n; req_inv = i; req_coreid = c; cpx_stall = s; err_inj = e;
        if (r) begin
            q.delete(); m_cnt = 0; m_flag = 0;
        end else begin
            can_push = v && q.size() < DEPTH;
            do_pop = q.size() > 0 && (cyc - q[0].t) >= MIN_LAT && !s;
            if (do_pop) begin
                h = q.pop_front();
                ev = 1; en = h.nc; ec = h.core; ew = h.inv;
`ifdef NC_INV_ERR_INJ_EN
                if (m_flag && h.nc) begin ew = 1; m_flag = 0; end
`endif
            end
`ifdef NC_INV_ERR_INJ_EN
            if (e) m_flag = 1;
`endif
            if (can_push) begin
                nw.nc = n; nw.inv = i & ~n; nw.core = c; nw.t = cyc;
                q.push_back(nw);
                if (n && i && m_cnt < 255) m_cnt++;
            end
        end
        @(posedge clk); #1;
        cyc++;
        if (cpxpkt_vld && nc && wv) nc_wv_seen++;
        check("pkt", {cpxpkt_vld, nc, wv, coreid}, {ev, en, ew, ec});
        check("ctl", {req_rdy, inv_supp_cnt, cpxpkt_rtntype},
              {!r && q.size() < DEPTH, 8'(m_cnt), 4'b0000});
    endtask

    initial begin
        tbl[0] = mk(1,0,0,0,0,0, 0,0,0,0,0,0);
        tbl[1] = mk(0,0,0,0,0,0, 0,0,0,0,1,0);
        tbl[2] = mk(0,1,0,1,5,0, 0,0,0,0,1,0);
        tbl[3] = mk(0,0,0,0,0,0, 0,0,0,0,1,0);
        tbl[4] = mk(0,0,0,0,0,0, 1,0,1,5,1,0);
        tbl[5] = mk(0,0,0,0,0,0, 0,0,0,0,1,0);
        tbl[6] = mk(0,1,1,1,3,0, 0,0,0,0,1,1);
        tbl[7] = mk(0,0,0,0,0,0, 0,0,0,0,1,1);
        tbl[8] = mk(0,0,0,0,0,0, 1,1,0,3,1,1);
        tbl[9] = mk(0,0,0,0,0,0, 0,0,0,0,1,1);
        for (int k = 10; k <= 14; k++)
            tbl[k] = mk(0,1,0,0,k,1, 0,0,0,0,k < 13,1);
        for (int k = 15; k <= 18; k++)
            tbl[k] = mk(0,0,0,0,0,0, 1,0,0,k-5,1,1);
        tbl[19] = mk(0,0,0,0,0,0, 0,0,0,0,1,1);
        tbl[20] = mk(0,1,0,0,20,0, 0,0,0,0,1,1);
        tbl[21] = mk(0,1,0,0,21,0, 0,0,0,0,1,1);
        for (int k = 22; k <= 24; k++)
            tbl[k] = mk(0,0,0,0,0,1, 0,0,0,0,1,1);
        tbl[25] = mk(0,0,0,0,0,0, 1,0,0,20,1,1);
        tbl[26] = mk(0,0,0,0,0,0, 1,0,0,21,1,1);
        tbl[27] = mk(0,0,0,0,0,0, 0,0,0,0,1,1);
        for (int k = 28; k <= 30; k++)
            tbl[k] = mk(0,1,0,0,k,1, 0,0,0,0,1,1);
        tbl[31] = mk(1,0,0,0,0,0, 0,0,0,0,0,0);
        for (int k = 32; k <= 35; k++)
            tbl[k] = mk(0,0,0,0,0,0, 0,0,0,0,1,0);

        for (int k = 0; k < 36; k++) begin
            rst = tbl[k].rst; req_vld = tbl[k].vld; req_nc = tbl[k].nc; req_inv = tbl[k].inv;
            req_coreid = CW'(tbl[k].core); cpx_stall = tbl[k].stall; err_inj = 0;
            @(posedge clk); #1;
            check($sformatf("vec%0d_pkt", k), {cpxpkt_vld, nc, wv, coreid},
                  {tbl[k].e_vld, tbl[k].e_nc, tbl[k].e_wv, CW'(tbl[k].e_core)});
            check($sformatf("vec%0d_rdy", k), req_rdy, tbl[k].e_rdy);
            check($sformatf("vec%0d_cnt", k), inv_supp_cnt, 8'(tbl[k].e_cnt));
            check($sformatf("vec%0d_rtn", k), cpxpkt_rtntype, 4'b0000);
        end

        cycle(1,0,0,0,'0,0,0);
        for (int k = 0; k < 1500; k++)
            cycle(0, $urandom_range(0,9) < 6, $urandom_range(0,1), $urandom_range(0,1),
                  CW'($urandom_range(0,1023)), $urandom_range(0,9) < 3, $urandom_range(0,19) == 0);

        cycle(1,0,0,0,'0,0,0);
        nc_wv_seen = 0;
        cycle(0,0,0,0,'0,0,1);
        cycle(0,1,0,0,CW'(100),0,0);
        cycle(0,1,1,0,CW'(101),0,0);
        cycle(0,1,1,0,CW'(102),0,0);
        for (int k = 0; k < 5; k++) cycle(0,0,0,0,'0,0,0);
`ifdef NC_INV_ERR_INJ_EN
        check("err_inj_nc_wv_pkts", nc_wv_seen, 1);
`else
        check("err_inj_nc_wv_pkts", nc_wv_seen, 0);
`endif

        cycle(1,0,0,0,'0,0,0);
        for (int k = 0; k < 300; k++) cycle(0,1,1,1,CW'(k),0,0);
        for (int k = 0; k < 4; k++) cycle(0,0,0,0,'0,0,0);
        check("inv_supp_sat", inv_supp_cnt, 8'd255);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
